logo_renderer: RTL and testbench
================================

Name: logo_renderer

Overview:
- Title-screen logo stage, directly upstream of the logo sprite ROM.
- Maps VGA scan position (DrawX/DrawY) to the ROM read_address and consumes the palette colour the ROM returns.
- Animates the logo: drop-in from above the screen, hold, exit upward on game start.
- Emits logo_on/logo_color to the colour mapper, with the transparency key colour filtered out.

Parameters:
LOGO_W, 352, logo width in pixels
LOGO_H, 176, logo height in pixels (LOGO_W*LOGO_H = 61952 ROM words)
REST_X, 144, fixed logo left edge (screen x)
REST_Y, 64, logo top edge when resting
DROP_STEP, 4, pixels moved down per frame in DROP
EXIT_STEP, 8, pixels moved up per frame in EXIT
KEY_COLOR, 24'h800080, transparent palette colour

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
frame_clk  in  1  VGA vertical sync; its rising edge is the frame tick
show  in  1  level; title screen active
start_pressed  in  1  single-cycle pulse; player started game
DrawX  in  10  current pixel x (0..799)
DrawY  in  10  current pixel y (0..524)
rom_color  in  24  colour returned by the logo ROM for read_address, combinational
read_address  out  18  logo ROM address
logo_on  out  1  pixel is an opaque logo pixel
logo_color  out  24  pixel colour, valid when logo_on
logo_done  out  1  one-cycle pulse when the exit animation completes
state_out  out  2  current FSM state, for debug/top level

Behaviour:
- Reset:
  - state HIDDEN (2'd0); logo_y = -LOGO_H (signed 11-bit).
  - read_address = 0, logo_on = 0, logo_color = 0, logo_done = 0.
  - All pipeline registers cleared.
- Frame tick:
  - frame_clk_d registers frame_clk.
  - tick = frame_clk & ~frame_clk_d, one Clk wide.
  - Position changes only on tick.
- FSM states: HIDDEN=0, DROP=1, HOLD=2, EXIT=3.
  - HIDDEN: logo_y held at -LOGO_H. show=1 -> DROP.
  - DROP:
    - On tick, logo_y += DROP_STEP, clamped to REST_Y.
    - When the update reaches REST_Y -> HOLD in the same cycle.
    - start_pressed -> EXIT from the current logo_y.
  - HOLD: logo_y = REST_Y. start_pressed -> EXIT.
  - EXIT:
    - On tick, logo_y -= EXIT_STEP, clamped to -LOGO_H.
    - On reaching -LOGO_H -> HIDDEN, with logo_done = 1 for exactly that cycle.
- show=0 in any state:
  - Next cycle: HIDDEN, logo_y = -LOGO_H, no logo_done.
  - show=0 has priority over start_pressed and tick.
- start_pressed in HIDDEN or EXIT is ignored.
- Simultaneous tick and start_pressed in DROP/HOLD: go to EXIT; this tick applies no movement.
- Pixel pipeline, stage 1 (registered):
  - rel_x = DrawX - REST_X; rel_y = DrawY - logo_y; signed 11-bit.
  - inside = DrawX < 640 & DrawY < 480 & 0 <= rel_x < LOGO_W & 0 <= rel_y < LOGO_H & state != HIDDEN.
  - read_address = inside ? rel_y*LOGO_W + rel_x : 0. 18-bit, max 61951, no wrap possible.
  - inside_q registered alongside read_address.
- Pixel pipeline, stage 2 (registered):
  - logo_on = inside_q & (rom_color != KEY_COLOR).
  - logo_color = logo_on ? rom_color : 0.
- Latency: DrawX/DrawY to logo_on/logo_color = 2 Clk, fixed, independent of state.
- Clipping: while logo_y < 0, rows above the screen are skipped; address offset uses the true rel_y, so visible rows are correct.
- Position update vs. active pixels:
  - logo_y used in stage 1 is the value in the register that cycle.
  - Updates fall in vertical blank because the tick is derived from vsync.
- Reset mid-animation: returns to HIDDEN within 1 cycle; logo_on = 0 on the following cycle; no logo_done.

Test Plan:
- Reset, hold show=0, apply 3 ticks -> state_out=0, logo_on=0, read_address=0, logo_done never 1.
- show=1, 60 ticks -> logo_y steps -176, -172, ..., 64. state_out=2 after tick 60, stays 2 on tick 61.
- In HOLD, DrawX=144, DrawY=64 -> read_address=0 after 1 Clk. DrawX=495, DrawY=239 -> 61951. DrawX=496 -> inside=0, address 0, logo_on=0 after 2 Clk.
- In HOLD, model ROM returning 24'h800080 then 24'h994E00 -> logo_on 0 then 1, logo_color=24'h994E00, each 2 Clk after its DrawX/DrawY.
- start_pressed in HOLD, then 30 ticks -> logo_y 56, 48, ..., -176. logo_done high exactly 1 Clk on the 30th tick, then state_out=0.
- show=1, 10 ticks (logo_y=-136), then start_pressed coincident with a tick -> EXIT with logo_y=-136 unchanged. 5 ticks later HIDDEN with logo_done pulse. Separately, deassert show mid-DROP -> HIDDEN next cycle, no pulse.

Source files
------------

// File: rtl/logo_renderer.sv
// Title-screen logo stage: animates the logo's vertical position from the vsync tick
// and maps the scan position to logo ROM addresses through a two-stage pixel pipeline.
module logo_renderer #(
    parameter int          LOGO_W    = 352,
    parameter int          LOGO_H    = 176,
    parameter int          REST_X    = 144,
    parameter int          REST_Y    = 64,
    parameter int          DROP_STEP = 4,
    parameter int          EXIT_STEP = 8,
    parameter logic [23:0] KEY_COLOR = 24'h800080
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        show,
    input  logic        start_pressed,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [23:0] rom_color,
    output logic [17:0] read_address,
    output logic        logo_on,
    output logic [23:0] logo_color,
    output logic        logo_done,
    output logic [1:0]  state_out
);

    typedef enum logic [1:0] {
        HIDDEN = 2'd0,
        DROP   = 2'd1,
        HOLD   = 2'd2,
        EXIT   = 2'd3
    } state_e;

    localparam logic signed [10:0] HIDE_Y = 11'(-LOGO_H);
    localparam logic signed [10:0] REST_Y_S = 11'(REST_Y);

    state_e             state_q, state_d;
    logic signed [10:0] y_q, y_d;
    logic signed [10:0] y_up, y_down;
    logic               done_q, done_d;
    logic               frame_clk_q;
    logic               tick;

    logic [10:0]        rel_x, rel_y;
    logic               inside_d, inside_q;
    logic [17:0]        addr_d, addr_q;
    logic               on_d, on_q;
    logic [23:0]        color_d, color_q;

    // vsync rising edge; position updates therefore land in vertical blank
    assign tick   = frame_clk & ~frame_clk_q;
    assign y_up   = y_q + 11'(DROP_STEP);
    assign y_down = y_q - 11'(EXIT_STEP);

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        done_d  = 1'b0;
        if (!show) begin
            state_d = HIDDEN;
            y_d     = HIDE_Y;
        end else begin
            case (state_q)
                HIDDEN: begin
                    y_d     = HIDE_Y;
                    state_d = DROP;
                end
                DROP: begin
                    // a start coinciding with a tick wins and freezes the position
                    if (start_pressed) begin
                        state_d = EXIT;
                    end else if (tick) begin
                        if (y_up >= REST_Y_S) begin
                            y_d     = REST_Y_S;
                            state_d = HOLD;
                        end else begin
                            y_d = y_up;
                        end
                    end
                end
                HOLD: begin
                    y_d = REST_Y_S;
                    if (start_pressed) begin
                        state_d = EXIT;
                    end
                end
                EXIT: begin
                    if (tick) begin
                        if (y_down <= HIDE_Y) begin
                            y_d     = HIDE_Y;
                            state_d = HIDDEN;
                            done_d  = 1'b1;
                        end else begin
                            y_d = y_down;
                        end
                    end
                end
                default: begin
                    state_d = HIDDEN;
                    y_d     = HIDE_Y;
                end
            endcase
        end
    end

    // Stage 1: both offsets are formed mod 2^11 and read as signed via bit 10
    assign rel_x = {1'b0, DrawX} - 11'(REST_X);
    assign rel_y = {1'b0, DrawY} - y_q;

    always_comb begin
        inside_d = (state_q != HIDDEN)
                 && (DrawX < 10'd640) && (DrawY < 10'd480)
                 && !rel_x[10] && (rel_x[9:0] < 10'(LOGO_W))
                 && !rel_y[10] && (rel_y[9:0] < 10'(LOGO_H));
        addr_d   = '0;
        if (inside_d) begin
            addr_d = {7'd0, rel_y} * 18'(LOGO_W) + {7'd0, rel_x};
        end
    end

    // Stage 2: the ROM answers for addr_q within the same cycle
    always_comb begin
        on_d    = inside_q && (rom_color != KEY_COLOR);
        color_d = on_d ? rom_color : 24'd0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= HIDDEN;
            y_q         <= HIDE_Y;
            done_q      <= 1'b0;
            frame_clk_q <= 1'b0;
            inside_q    <= 1'b0;
            addr_q      <= '0;
            on_q        <= 1'b0;
            color_q     <= '0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            done_q      <= done_d;
            frame_clk_q <= frame_clk;
            inside_q    <= inside_d;
            addr_q      <= addr_d;
            on_q        <= on_d;
            color_q     <= color_d;
        end
    end

    assign read_address = addr_q;
    assign logo_on      = on_q;
    assign logo_color   = color_q;
    assign logo_done    = done_q;
    assign state_out    = state_q;

endmodule

// File: tb/tb_logo_renderer.sv
// Bench for logo_renderer: a cycle-level reference of the logo animation and pixel
// mapping, driven by directed sequences plus random scan positions and control.
module tb_logo_renderer;

    localparam logic [23:0] KEY = 24'h800080;

    logic        Clk;
    logic        Reset;
    logic        frame_clk;
    logic        show;
    logic        start_pressed;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [23:0] rom_color;
    logic [17:0] read_address;
    logic        logo_on;
    logic [23:0] logo_color;
    logic        logo_done;
    logic [1:0]  state_out;

    int errors = 0;
    int checks = 0;

    // reference state: 0 hidden, 1 drop, 2 hold, 3 exit; m_y is the logo top row
    int m_state = 0;
    int m_y = -176;
    bit fc_prev = 1'b0;
    int m_done_cnt = 0;
    int dut_done_cnt = 0;
    int px = 0;
    int py = 0;

    // pending stage-1 predictions: {inside, address}
    logic [18:0] exp_q[$];

    bit          rom_ovr_en = 1'b0;
    logic [23:0] rom_ovr_val = 24'd0;

    logo_renderer dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .show         (show),
        .start_pressed(start_pressed),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .rom_color    (rom_color),
        .read_address (read_address),
        .logo_on      (logo_on),
        .logo_color   (logo_color),
        .logo_done    (logo_done),
        .state_out    (state_out)
    );

    // clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [23:0] rom_fn(input logic [17:0] a);
        logic [31:0] h;
        if (a % 18'd5 == 18'd0) return KEY;
        h = ({14'd0, a} * 32'd40503) ^ 32'h00A5_3C19;
        return h[23:0];
    endfunction

    assign rom_color = rom_ovr_en ? rom_ovr_val : rom_fn(read_address);

    always @(negedge Clk) begin
        if (logo_done === 1'b1) dut_done_cnt++;
    end

    function automatic void pix_model(input int x, input int y, input int ly, input int st,
                                      output bit ins, output int addr);
        int rx;
        int ry;
        rx   = x - 144;
        ry   = y - ly;
        ins  = (st != 0) && (x < 640) && (y < 480) && (rx >= 0) && (rx < 352)
               && (ry >= 0) && (ry < 176);
        addr = ins ? ry * 352 + rx : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        Reset         = 1'b1;
        start_pressed = 1'b0;
        frame_clk     = 1'b0;
        fc_prev       = 1'b0;
        @(posedge Clk);
        #1;
        m_state = 0;
        m_y     = -176;
        exp_q.delete();
        exp_q.push_back(19'd0);
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_addr", 32'(read_address), 32'd0);
        chk("rst_on", 32'(logo_on), 32'd0);
        chk("rst_color", 32'(logo_color), 32'd0);
        chk("rst_done", 32'(logo_done), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // one clock: apply inputs, advance the reference, compare every output
    task automatic step(input bit st, input bit tk);
        bit          tick_m;
        bit          ins;
        int          addr;
        logic [18:0] prev;
        logic [23:0] rv;
        bit          exp_on;
        bit          exp_done;
        start_pressed = st;
        frame_clk     = tk;
        DrawX         = 10'(px);
        DrawY         = 10'(py);
        tick_m        = tk && !fc_prev;
        fc_prev       = tk;
        pix_model(px, py, m_y, m_state, ins, addr);
        prev = exp_q.pop_front();
        exp_q.push_back({ins, 18'(addr)});
        @(posedge Clk);
        #1;
        rv       = rom_ovr_en ? rom_ovr_val : rom_fn(prev[17:0]);
        exp_on   = prev[18] && (rv != KEY);
        exp_done = 1'b0;
        if (!show) begin
            m_state = 0;
            m_y     = -176;
        end else begin
            case (m_state)
                0: m_state = 1;
                1: begin
                    if (st) m_state = 3;
                    else if (tick_m) begin
                        m_y = (m_y + 4 > 64) ? 64 : m_y + 4;
                        if (m_y == 64) m_state = 2;
                    end
                end
                2: if (st) m_state = 3;
                default: begin
                    if (tick_m) begin
                        m_y = (m_y - 8 < -176) ? -176 : m_y - 8;
                        if (m_y == -176) begin
                            m_state  = 0;
                            exp_done = 1'b1;
                            m_done_cnt++;
                        end
                    end
                end
            endcase
        end
        chk("state", 32'(state_out), 32'(m_state));
        chk("done", 32'(logo_done), 32'(exp_done));
        chk("addr", 32'(read_address), 32'(addr));
        chk("on", 32'(logo_on), 32'(exp_on));
        chk("color", 32'(logo_color), exp_on ? 32'(rv) : 32'd0);
        @(negedge Clk);
        start_pressed = 1'b0;
    endtask

    task automatic rnd_pix();
        if ($urandom_range(0, 1) == 0) begin
            px = $urandom_range(100, 520);
            py = $urandom_range(0, 300);
        end else begin
            px = $urandom_range(0, 799);
            py = $urandom_range(0, 524);
        end
    endtask

    // one frame tick followed by two idle cycles with random scan positions
    task automatic frame(input bit st_on_tick);
        rnd_pix();
        step(st_on_tick, 1'b1);
        repeat (2) begin
            rnd_pix();
            step(1'b0, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        Reset         = 1'b1;
        frame_clk     = 1'b0;
        show          = 1'b0;
        start_pressed = 1'b0;
        DrawX         = '0;
        DrawY         = '0;
        do_reset();
        do_reset();

        // hidden while show is low, ticks have no effect
        repeat (3) frame(1'b0);
        chk("hidden_state", 32'(state_out), 32'd0);

        // drop-in: 60 ticks reach the rest row, one more tick stays put
        show = 1'b1;
        rnd_pix();
        step(1'b0, 1'b0);
        repeat (60) frame(1'b0);
        chk("hold_after_60", 32'(state_out), 32'd2);
        frame(1'b0);
        chk("hold_after_61", 32'(state_out), 32'd2);

        // address corners at rest
        px = 144; py = 64;
        step(1'b0, 1'b0);
        chk("addr_origin", 32'(read_address), 32'd0);
        px = 495; py = 239;
        step(1'b0, 1'b0);
        chk("addr_last", 32'(read_address), 32'd61951);
        px = 496;
        step(1'b0, 1'b0);
        chk("addr_right_out", 32'(read_address), 32'd0);
        step(1'b0, 1'b0);
        chk("on_right_out", 32'(logo_on), 32'd0);

        // transparency key then an opaque colour
        px = 300; py = 150;
        rom_ovr_en  = 1'b1;
        rom_ovr_val = KEY;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("on_key", 32'(logo_on), 32'd0);
        rom_ovr_val = 24'h994E00;
        step(1'b0, 1'b0);
        chk("on_opaque", 32'(logo_on), 32'd1);
        chk("color_opaque", 32'(logo_color), 32'h994E00);
        rom_ovr_en = 1'b0;

        // exit from rest: 30 ticks to fully hidden, with one done pulse
        step(1'b1, 1'b0);
        chk("exit_entered", 32'(state_out), 32'd3);
        repeat (30) frame(1'b0);
        chk("done_cnt_exit", 32'(dut_done_cnt), 32'(m_done_cnt));

        // show still high: logo drops again; start coincident with tick at y=-136
        repeat (10) frame(1'b0);
        frame(1'b1);
        chk("exit_coincident", 32'(state_out), 32'd3);
        repeat (5) frame(1'b0);
        chk("done_cnt_short", 32'(dut_done_cnt), 32'(m_done_cnt));

        // show withdrawn mid-drop
        repeat (3) frame(1'b0);
        show = 1'b0;
        rnd_pix();
        step(1'b0, 1'b0);
        chk("show_off_hidden", 32'(state_out), 32'd0);
        step(1'b0, 1'b0);

        // reset mid-drop
        show = 1'b1;
        repeat (4) frame(1'b0);
        do_reset();
        rnd_pix();
        step(1'b0, 1'b0);

        // random control and scan positions
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 120) == 0) show = ~show;
            rnd_pix();
            step($urandom_range(0, 40) == 0, $urandom_range(0, 2) == 0);
        end

        chk("done_cnt_total", 32'(dut_done_cnt), 32'(m_done_cnt));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
